// File: rtl/jt900h_busctl_if.sv
// External 16-bit word bus between the bus bridge and memory/peripherals.
//   master : bridge side (drives address, write data, strobes; samples data and ready)
//   slave  : memory side (drives read data and ready)
interface jt900h_busctl_if;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_dout;
    logic [DW-1:0] bus_din;
    logic          bus_cs;
    logic          bus_rd;
    logic [1:0]    bus_we;
    logic          bus_ok;

    modport master (
        output bus_addr, bus_dout, bus_cs, bus_rd, bus_we,
        input  bus_din, bus_ok
    );

    modport slave (
        input  bus_addr, bus_dout, bus_cs, bus_rd, bus_we,
        output bus_din, bus_ok
    );
endinterface

// File: rtl/jt900h_busctl.sv
// Bridge from the CPU RAM controller's zero-wait 16-bit interface onto an
// external word bus with chip select, wait states and a ready handshake.
// The CPU is stalled through cpu_cen until each access completes; a one-word
// read latch lets repeated reads of the same word finish without bus cycles.
//   clk, rst          : clock, asynchronous active-low reset
//   cen               : master clock enable
//   cpu_cen           : gated clock enable back to CPU / RAM controller
//   cpu_addr/din/we   : byte address, write data, byte write mask (0 = read)
//   cpu_dout          : read data to the RAM controller
//   wait_cfg          : extra wait states outside the internal RAM window
//   bus               : external bus (master side)
module jt900h_busctl #(
    parameter logic [23:0] IRAM_START = 24'h004000,
    parameter logic [23:0] IRAM_END   = 24'h007FFF,
    parameter int unsigned WAIT_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    output logic              cpu_cen,
    input  logic [23:0]       cpu_addr,
    input  logic [15:0]       cpu_din,
    input  logic [1:0]        cpu_we,
    output logic [15:0]       cpu_dout,
    input  logic [WAIT_W-1:0] wait_cfg,
    jt900h_busctl_if.master   bus
);
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q,  addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              cs_q,    cs_d;
    logic              rd_q,    rd_d;
    logic [1:0]        we_q,    we_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [AW-1:1]     lat_q,   lat_d;
    logic              lat_ok_q, lat_ok_d;
    logic              wr_done_q, wr_done_d;
    logic [WAIT_W-1:0] cnt_q,   cnt_d;

    logic need;
    logic in_iram;
    logic idle;

    // Start request: an unfinished write, or a read that misses the latch
    assign need = ((cpu_we != 2'b00) && !wr_done_q) ||
                  ((cpu_we == 2'b00) && (!lat_ok_q || (cpu_addr[AW-1:1] != lat_q)));

    assign in_iram = (cpu_addr >= IRAM_START) && (cpu_addr <= IRAM_END);
    assign idle    = (state_q == IDLE);

    // Stall appears in the same cycle the new address does
    assign cpu_cen = cen & idle & ~need;

    assign bus.bus_addr = addr_q;
    assign bus.bus_dout = wdata_q;
    assign bus.bus_cs   = cs_q;
    assign bus.bus_rd   = rd_q;
    assign bus.bus_we   = we_q;
    assign cpu_dout     = rdata_q;

    // Next-state and register update logic
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cs_d      = cs_q;
        rd_d      = rd_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        lat_d     = lat_q;
        lat_ok_d  = lat_ok_q;
        wr_done_d = wr_done_q;
        cnt_d     = cnt_q;

        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (need) begin
                        addr_d = {cpu_addr[AW-1:1], 1'b0};
                        cnt_d  = in_iram ? '0 : wait_cfg;
                        cs_d   = 1'b1;
                        if (cpu_we != 2'b00) begin
                            wdata_d = cpu_din;
                            we_d    = cpu_we;
                            state_d = WR;
                        end else begin
                            rd_d    = 1'b1;
                            state_d = RD;
                        end
                    end else if (cpu_we != 2'b00) begin
                        // cpu_cen is high here: this is the write-finished pulse
                        wr_done_d = 1'b0;
                    end
                end
                RD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else if (bus.bus_ok) begin
                        rdata_d  = bus.bus_din;
                        lat_d    = addr_q[AW-1:1];
                        lat_ok_d = 1'b1;
                        cs_d     = 1'b0;
                        rd_d     = 1'b0;
                        state_d  = IDLE;
                    end
                end
                WR: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end else if (bus.bus_ok) begin
                        wr_done_d = 1'b1;
                        cs_d      = 1'b0;
                        we_d      = 2'b00;
                        state_d   = IDLE;
                        // Keep the read latch coherent with the written bytes
                        if (lat_ok_q && (addr_q[AW-1:1] == lat_q)) begin
                            if (we_q[1]) rdata_d[15:8] = wdata_q[15:8];
                            if (we_q[0]) rdata_d[7:0]  = wdata_q[7:0];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            cs_q      <= 1'b0;
            rd_q      <= 1'b0;
            we_q      <= 2'b00;
            rdata_q   <= '0;
            lat_q     <= '0;
            lat_ok_q  <= 1'b0;
            wr_done_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            lat_q     <= lat_d;
            lat_ok_q  <= lat_ok_d;
            wr_done_q <= wr_done_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_jt900h_busctl.sv
// Directed bench for jt900h_busctl: a per-cycle vector table plus a
// hand-written write sequence with wait states and a delayed ready.
module tb_jt900h_busctl;
    logic        clk;
    logic        rst;
    logic        cen;
    logic        cpu_cen;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_we;
    logic [15:0] cpu_dout;
    logic [1:0]  wait_cfg;

    jt900h_busctl_if bif ();

    jt900h_busctl dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .cpu_cen  (cpu_cen),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_we   (cpu_we),
        .cpu_dout (cpu_dout),
        .wait_cfg (wait_cfg),
        .bus      (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        cen;
        logic [23:0] addr;
        logic [15:0] din;
        logic [1:0]  we;
        logic [1:0]  wcfg;
        logic [15:0] bdin;
        logic        ok;
        logic        e_cen;
        logic        e_cs;
        logic        e_rd;
        logic [1:0]  e_we;
        logic [23:0] e_addr;
        logic [15:0] e_bdout;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    task automatic add(input logic r, input logic c, input logic [23:0] a,
                       input logic [15:0] d, input logic [1:0] w, input logic [1:0] wc,
                       input logic [15:0] bd, input logic ok,
                       input logic ecen, input logic ecs, input logic erd,
                       input logic [1:0] ewe, input logic [23:0] eaddr,
                       input logic [15:0] ebdout, input logic [15:0] edout);
        vec_t v;
        v.rst = r; v.cen = c; v.addr = a; v.din = d; v.we = w; v.wcfg = wc;
        v.bdin = bd; v.ok = ok;
        v.e_cen = ecen; v.e_cs = ecs; v.e_rd = erd; v.e_we = ewe;
        v.e_addr = eaddr; v.e_bdout = ebdout; v.e_dout = edout;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_obs();
        return {3'b0, cpu_cen, bif.bus_cs, bif.bus_rd, bif.bus_we,
                bif.bus_addr, bif.bus_dout, cpu_dout};
    endfunction

    initial begin
        int stall;
        int c;
        logic [63:0] exp_v;

        n_cmp = 0;
        n_err = 0;
        rst = 1'b0; cen = 1'b1; cpu_addr = 24'h004010; cpu_din = '0; cpu_we = 2'b00;
        wait_cfg = 2'd0; bif.bus_din = 16'hA55A; bif.bus_ok = 1'b1;

        // rst cen addr din we wc bdin ok | cpu_cen cs rd we addr bdout dout
        add(0,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 0,0,0,2'b00,24'h000000,16'h0000,16'h0000);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 0,0,0,2'b00,24'h000000,16'h0000,16'h0000);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 0,1,1,2'b00,24'h004010,16'h0000,16'h0000);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        add(1,1,24'h004011,16'h0000,2'b00,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        // 3 wait states, one frozen cen cycle in the middle, wait_cfg changed mid-access
        add(1,0,24'h200000,16'h0000,2'b00,2'd3,16'h1234,1, 0,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd3,16'h1234,1, 0,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 0,1,1,2'b00,24'h200000,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 0,1,1,2'b00,24'h200000,16'h0000,16'hA55A);
        add(1,0,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 0,1,1,2'b00,24'h200000,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 0,1,1,2'b00,24'h200000,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 0,1,1,2'b00,24'h200000,16'h0000,16'hA55A);
        add(1,1,24'h200000,16'h0000,2'b00,2'd0,16'h1234,1, 1,0,0,2'b00,24'h200000,16'h0000,16'h1234);
        // Ready stall: bus_ok low for 5 cycles
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,0,0,2'b00,24'h200000,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,0, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,1, 0,1,1,2'b00,24'h200100,16'h0000,16'h1234);
        add(1,1,24'h200100,16'h0000,2'b00,2'd0,16'h5678,1, 1,0,0,2'b00,24'h200100,16'h0000,16'h5678);
        // Reload latch with A55A at 004010, then merged writes
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 0,0,0,2'b00,24'h200100,16'h0000,16'h5678);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 0,1,1,2'b00,24'h004010,16'h0000,16'h5678);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        add(1,1,24'h004010,16'h3C00,2'b10,2'd0,16'hA55A,1, 0,0,0,2'b00,24'h004010,16'h0000,16'hA55A);
        add(1,1,24'h004010,16'h3C00,2'b10,2'd0,16'hA55A,1, 0,1,0,2'b10,24'h004010,16'h3C00,16'hA55A);
        add(1,1,24'h004010,16'h3C00,2'b10,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h3C00,16'h3C5A);
        add(1,1,24'h004010,16'h0000,2'b00,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h3C00,16'h3C5A);
        add(1,1,24'h004010,16'h00EE,2'b01,2'd0,16'hA55A,1, 0,0,0,2'b00,24'h004010,16'h3C00,16'h3C5A);
        add(1,1,24'h004010,16'h00EE,2'b01,2'd0,16'hA55A,1, 0,1,0,2'b01,24'h004010,16'h00EE,16'h3C5A);
        add(1,1,24'h004010,16'h00EE,2'b01,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h00EE,16'h3CEE);
        add(1,1,24'h004011,16'h0000,2'b00,2'd0,16'hA55A,1, 1,0,0,2'b00,24'h004010,16'h00EE,16'h3CEE);
        // Region boundary: last IRAM byte has no waits, IRAM_END+1 takes wait_cfg
        add(1,1,24'h007FFF,16'h0000,2'b00,2'd1,16'h1111,1, 0,0,0,2'b00,24'h004010,16'h00EE,16'h3CEE);
        add(1,1,24'h007FFF,16'h0000,2'b00,2'd1,16'h1111,1, 0,1,1,2'b00,24'h007FFE,16'h00EE,16'h3CEE);
        add(1,1,24'h007FFF,16'h0000,2'b00,2'd1,16'h1111,1, 1,0,0,2'b00,24'h007FFE,16'h00EE,16'h1111);
        add(1,1,24'h008000,16'h0000,2'b00,2'd1,16'h2222,1, 0,0,0,2'b00,24'h007FFE,16'h00EE,16'h1111);
        add(1,1,24'h008000,16'h0000,2'b00,2'd1,16'h2222,1, 0,1,1,2'b00,24'h008000,16'h00EE,16'h1111);
        add(1,1,24'h008000,16'h0000,2'b00,2'd1,16'h2222,1, 0,1,1,2'b00,24'h008000,16'h00EE,16'h1111);
        add(1,1,24'h008000,16'h0000,2'b00,2'd1,16'h2222,1, 1,0,0,2'b00,24'h008000,16'h00EE,16'h2222);
        // Reset in the middle of a waited read; latch must be invalid afterwards
        add(1,1,24'h200000,16'h0000,2'b00,2'd3,16'h9999,1, 0,0,0,2'b00,24'h008000,16'h00EE,16'h2222);
        add(1,1,24'h200000,16'h0000,2'b00,2'd3,16'h9999,1, 0,1,1,2'b00,24'h200000,16'h00EE,16'h2222);
        add(0,1,24'h200000,16'h0000,2'b00,2'd3,16'h9999,1, 0,0,0,2'b00,24'h000000,16'h0000,16'h0000);
        add(1,1,24'h008000,16'h0000,2'b00,2'd0,16'h4444,1, 0,0,0,2'b00,24'h000000,16'h0000,16'h0000);
        add(1,1,24'h008000,16'h0000,2'b00,2'd0,16'h4444,1, 0,1,1,2'b00,24'h008000,16'h0000,16'h0000);
        add(1,1,24'h008000,16'h0000,2'b00,2'd0,16'h4444,1, 1,0,0,2'b00,24'h008000,16'h0000,16'h4444);

        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; cen = vecs[i].cen; cpu_addr = vecs[i].addr;
            cpu_din = vecs[i].din; cpu_we = vecs[i].we; wait_cfg = vecs[i].wcfg;
            bif.bus_din = vecs[i].bdin; bif.bus_ok = vecs[i].ok;
            #1;
            exp_v = {3'b0, vecs[i].e_cen, vecs[i].e_cs, vecs[i].e_rd, vecs[i].e_we,
                     vecs[i].e_addr, vecs[i].e_bdout, vecs[i].e_dout};
            chk($sformatf("vec%0d", i), pack_obs(), exp_v);
        end

        // Write with 2 waits and bus_ok delayed 3 cycles: stall = 1 + 2 + 3 + 1
        stall = 0;
        c = 0;
        cpu_addr = 24'h300000; cpu_din = 16'hBEEF; cpu_we = 2'b11; wait_cfg = 2'd2;
        while (c < 50) begin
            @(negedge clk);
            bif.bus_ok = (c >= 6);
            #1;
            if (c == 1) begin
                chk("wr_strobes", {24'b0, bif.bus_cs, bif.bus_rd, bif.bus_we, bif.bus_addr, bif.bus_dout},
                    {24'b0, 1'b1, 1'b0, 2'b11, 24'h300000, 16'hBEEF});
            end
            if (cpu_cen) break;
            stall++;
            c++;
        end
        chk("wr_stall", 64'(stall), 64'd7);
        chk("wr_other_word_keeps_latch", 64'(cpu_dout), 64'h4444);

        // Still holding cpu_we after the pulse starts a new write
        @(negedge clk);
        #1;
        chk("rewrite_after_pulse", 64'(cpu_cen), 64'd0);
        stall = 1;
        c = 0;
        while (c < 50) begin
            @(negedge clk);
            #1;
            if (cpu_cen) break;
            stall++;
            c++;
        end
        chk("rewrite_stall", 64'(stall), 64'd4);

        // Drop the write; read of the latched word hits with no bus access
        @(negedge clk);
        cpu_we = 2'b00; cpu_addr = 24'h008001;
        #1;
        chk("latch_hit_after_write", {46'b0, cpu_cen, bif.bus_cs, cpu_dout}, {46'b0, 1'b1, 1'b0, 16'h4444});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
